// File: rtl/sequenciador_musica.sv
// sequenciador_musica
//   Plays one song from the note memory and scores the player against it.
//   A start latches the song number and walks note addresses 0..15. Each
//   note is held for a window of TICKS_PER_NOTE cycles. During that window
//   the player buttons are compared against the current note. Every note
//   then scores as exactly one hit or one miss.
//
// Ports
//   clock, reset   single clock domain; synchronous active-high reset
//   iniciar        start request (honoured only in IDLE or DONE)
//   parar          abort request (wins over iniciar; ignored in IDLE)
//   select_musica  song choice, latched when a start is accepted
//   botoes         synchronised player buttons, one bit per note lane
//   nota_rom       note memory output, valid one cycle after address
//   address        note index presented to the memory
//   musica_sel     latched song number presented to the memory
//   nota_atual     note being played; 0 when nothing is playing
//   tocando        high while a song is in progress
//   nota_valida    one-cycle pulse after each note is scored
//   fim_musica     high once the whole song has been scored
//   acertos/erros  hit and miss counts (0..16)
//
// Handshake: there is no valid/ready pairing here. iniciar and parar are
// level requests sampled on every rising clock edge. nota_rom is trusted
// one cycle after address/musica_sel change (registered memory read).

module sequenciador_musica #(
    parameter int TICKS_PER_NOTE = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [2:0] select_musica,
    input  logic [6:0] botoes,
    input  logic [6:0] nota_rom,
    output logic [3:0] address,
    output logic [2:0] musica_sel,
    output logic [6:0] nota_atual,
    output logic       tocando,
    output logic       nota_valida,
    output logic       fim_musica,
    output logic [4:0] acertos,
    output logic [4:0] erros
);

    localparam int CW = $clog2(TICKS_PER_NOTE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        SCORE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   tick;
    logic            hit;

    wire last_tick = (tick == CW'(TICKS_PER_NOTE - 1));
    wire last_note = (address == 4'd15);

    // A press counts only if it is exactly the current note and that note
    // is a real note (0 means a rest that cannot be hit).
    wire match = (botoes == nota_atual) && (nota_atual != 7'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (parar && state != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (iniciar && !parar) state_next = FETCH;
                FETCH:   state_next = LOAD;
                LOAD:    state_next = PLAY;
                PLAY:    if (last_tick) state_next = SCORE;
                SCORE:   state_next = last_note ? DONE : FETCH;
                DONE:    if (iniciar) state_next = FETCH;
                default: state_next = IDLE;
            endcase
        end
    end

    assign tocando = (state == FETCH) || (state == LOAD) ||
                     (state == PLAY)  || (state == SCORE);

    always_ff @(posedge clock) begin
        if (reset) begin
            address     <= 4'd0;
            musica_sel  <= 3'd0;
            nota_atual  <= 7'd0;
            nota_valida <= 1'b0;
            fim_musica  <= 1'b0;
            acertos     <= 5'd0;
            erros       <= 5'd0;
            tick        <= '0;
            hit         <= 1'b0;
        end else begin
            nota_valida <= 1'b0;
            if (parar) begin
                // Abort keeps the partial score and position visible.
                nota_atual <= 7'd0;
                fim_musica <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (iniciar) begin
                            musica_sel <= select_musica;
                            address    <= 4'd0;
                            acertos    <= 5'd0;
                            erros      <= 5'd0;
                            fim_musica <= 1'b0;
                        end
                    end
                    LOAD: begin
                        nota_atual <= nota_rom;
                        tick       <= '0;
                        hit        <= 1'b0;
                    end
                    PLAY: begin
                        tick <= tick + CW'(1);
                        // Sticky: later wrong presses never clear a hit.
                        if (match) hit <= 1'b1;
                    end
                    SCORE: begin
                        if (hit) acertos <= acertos + 5'd1;
                        else     erros   <= erros + 5'd1;
                        nota_valida <= 1'b1;
                        if (last_note) begin
                            nota_atual <= 7'd0;
                            fim_musica <= 1'b1;
                        end else begin
                            address <= address + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequenciador_musica.sv
// Bench for sequenciador_musica with TICKS_PER_NOTE=4 (7 cycles per note).
// A registered song memory lives in the bench. The expected behaviour is
// derived from the cycle index since start: note k occupies cycles 7k..7k+6,
// and its window is cycles 7k+2..7k+5.

module tb_sequenciador_musica;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       parar = 1'b0;
    logic [2:0] select_musica = 3'd0;
    logic [6:0] botoes = 7'd0;
    logic [6:0] nota_rom;
    logic [3:0] address;
    logic [2:0] musica_sel;
    logic [6:0] nota_atual;
    logic       tocando;
    logic       nota_valida;
    logic       fim_musica;
    logic [4:0] acertos;
    logic [4:0] erros;

    sequenciador_musica #(.TICKS_PER_NOTE(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
        .select_musica(select_musica), .botoes(botoes), .nota_rom(nota_rom),
        .address(address), .musica_sel(musica_sel), .nota_atual(nota_atual),
        .tocando(tocando), .nota_valida(nota_valida), .fim_musica(fim_musica),
        .acertos(acertos), .erros(erros)
    );

    always #5 clock = ~clock;

    // Song memory: registered read, one cycle of latency.
    logic [6:0] rom [8][16];
    always @(posedge clock) nota_rom <= rom[musica_sel][address];

    int passed = 0;
    int total = 0;
    logic [6:0] exp_q[$];
    bit   hit [16];
    int   exp_ac, exp_er, val_count;
    logic [2:0] exp_sel = 3'd0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_song(input int song);
        select_musica = 3'(song);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        exp_sel = 3'(song);
        exp_q.delete();
        for (int a = 0; a < 16; a++) begin
            exp_q.push_back(rom[song][a]);
            hit[a] = 1'b0;
        end
        exp_ac = 0;
        exp_er = 0;
        val_count = 0;
    endtask

    // mode 0: no presses, 1: exact note on every window cycle, 2: random mix.
    task automatic play_cycles(input int mode, input int n, input bit rand_ini);
        logic [6:0] b, note, e_nota;
        logic [3:0] e_addr;
        int k, ph;
        for (int c = 0; c < n; c++) begin
            k = c / 7;
            ph = c % 7;
            if (c > 0 && ph == 0 && c <= 112) begin
                if (hit[k-1]) exp_ac++;
                else exp_er++;
            end
            e_addr = (c < 112) ? 4'(k) : 4'd15;
            if (c >= 112)    e_nota = 7'd0;
            else if (ph >= 2) e_nota = exp_q[k];
            else if (k == 0)  e_nota = 7'd0;
            else              e_nota = exp_q[k-1];

            total++;
            if (address !== e_addr) $display("FAIL address c=%0d got %0d exp %0d", c, address, e_addr);
            else passed++;
            total++;
            if (nota_atual !== e_nota) $display("FAIL nota_atual c=%0d got %b exp %b", c, nota_atual, e_nota);
            else passed++;
            total++;
            if (tocando !== (c < 112)) $display("FAIL tocando c=%0d got %b exp %b", c, tocando, (c < 112));
            else passed++;
            total++;
            if (fim_musica !== (c >= 112)) $display("FAIL fim_musica c=%0d got %b exp %b", c, fim_musica, (c >= 112));
            else passed++;
            total++;
            if (nota_valida !== (c > 0 && ph == 0 && c <= 112))
                $display("FAIL nota_valida c=%0d got %b exp %b", c, nota_valida, (c > 0 && ph == 0 && c <= 112));
            else passed++;
            total++;
            if (acertos !== 5'(exp_ac) || erros !== 5'(exp_er))
                $display("FAIL score c=%0d got %0d/%0d exp %0d/%0d", c, acertos, erros, exp_ac, exp_er);
            else passed++;
            total++;
            if (musica_sel !== exp_sel) $display("FAIL musica_sel c=%0d got %0d exp %0d", c, musica_sel, exp_sel);
            else passed++;
            if (nota_valida === 1'b1) val_count++;

            note = (c < 112) ? exp_q[k] : 7'd0;
            case (mode)
                0: b = 7'd0;
                1: b = (ph >= 2 && ph <= 5) ? note : 7'd0;
                default: begin
                    case ($urandom_range(0, 3))
                        0: b = 7'd0;
                        1: b = note;
                        2: b = note | 7'(1 << $urandom_range(0, 6));
                        default: b = 7'($urandom_range(0, 127));
                    endcase
                end
            endcase
            if (c < 112 && ph >= 2 && ph <= 5 && b == note && note != 7'd0) hit[k] = 1'b1;
            botoes = b;
            if (rand_ini) begin
                select_musica = 3'($urandom_range(0, 7));
                iniciar = (c < 112) && ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        iniciar = 1'b0;
        botoes = 7'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            total++;
            if ({address, musica_sel, nota_atual, tocando, nota_valida, fim_musica, acertos, erros} !== '0)
                $display("FAIL reset_outputs i=%0d got addr=%0d sel=%0d nota=%b toc=%b val=%b fim=%b ac=%0d er=%0d exp all 0",
                         i, address, musica_sel, nota_atual, tocando, nota_valida, fim_musica, acertos, erros);
            else passed++;
            tick();
        end
    endtask

    task automatic test_no_hits();
        start_song(2);
        play_cycles(0, 113, 1'b0);
        total++;
        if (erros !== 5'd16 || acertos !== 5'd0)
            $display("FAIL no_hits_final got %0d/%0d exp 0/16", acertos, erros);
        else passed++;
    endtask

    task automatic test_all_hits();
        start_song(0);
        play_cycles(1, 113, 1'b0);
        total++;
        if (acertos !== 5'd16 || erros !== 5'd0)
            $display("FAIL all_hits_final got %0d/%0d exp 16/0", acertos, erros);
        else passed++;
        total++;
        if (val_count != 16) $display("FAIL valid_pulses got %0d exp 16", val_count);
        else passed++;
    endtask

    task automatic test_random_mix();
        start_song(7);
        play_cycles(2, 113, 1'b1);
        total++;
        if (32'(acertos) + 32'(erros) != 16)
            $display("FAIL mix_sum got %0d exp 16", acertos + erros);
        else passed++;
    endtask

    task automatic test_parar();
        start_song(int'($urandom_range(0, 6)));
        play_cycles(2, 7 * 5 + 3, 1'b0);
        parar = 1'b1;
        tick();
        parar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tocando !== 1'b0 || nota_atual !== 7'd0 || fim_musica !== 1'b0 || nota_valida !== 1'b0)
                $display("FAIL parar_idle i=%0d got toc=%b nota=%b fim=%b val=%b exp 0", i, tocando, nota_atual, fim_musica, nota_valida);
            else passed++;
            total++;
            if (acertos !== 5'(exp_ac) || erros !== 5'(exp_er) || 32'(acertos) + 32'(erros) != 5)
                $display("FAIL parar_score i=%0d got %0d/%0d exp %0d/%0d", i, acertos, erros, exp_ac, exp_er);
            else passed++;
            total++;
            if (address !== 4'd5 || musica_sel !== exp_sel)
                $display("FAIL parar_hold i=%0d got addr=%0d sel=%0d exp addr=5 sel=%0d", i, address, musica_sel, exp_sel);
            else passed++;
            tick();
        end
    endtask

    task automatic test_start_stop_priority();
        select_musica = 3'd5;
        iniciar = 1'b1;
        parar = 1'b1;
        tick();
        iniciar = 1'b0;
        parar = 1'b0;
        tick();
        total++;
        if (tocando !== 1'b0 || address !== 4'd5 || musica_sel !== exp_sel)
            $display("FAIL both_req got toc=%b addr=%0d sel=%0d exp toc=0 addr=5 sel=%0d", tocando, address, musica_sel, exp_sel);
        else passed++;
        // Random start pulses and song changes while playing must be ignored.
        start_song(1);
        play_cycles(1, 113, 1'b1);
    endtask

    task automatic test_restart_from_done();
        select_musica = 3'd3;
        iniciar = 1'b1;
        tick();
        total++;
        if (tocando !== 1'b1 || fim_musica !== 1'b0 || acertos !== 5'd0 || erros !== 5'd0 ||
            address !== 4'd0 || musica_sel !== 3'd3)
            $display("FAIL restart got toc=%b fim=%b ac=%0d er=%0d addr=%0d sel=%0d exp 1/0/0/0/0/3",
                     tocando, fim_musica, acertos, erros, address, musica_sel);
        else passed++;
        select_musica = 3'd6;
        tick();
        total++;
        if (tocando !== 1'b1 || musica_sel !== 3'd3 || address !== 4'd0)
            $display("FAIL restart_held got toc=%b sel=%0d addr=%0d exp 1/3/0", tocando, musica_sel, address);
        else passed++;
        iniciar = 1'b0;
        parar = 1'b1;
        tick();
        parar = 1'b0;
        total++;
        if (tocando !== 1'b0) $display("FAIL restart_stop got toc=%b exp 0", tocando);
        else passed++;
    endtask

    task automatic test_reset_mid_song();
        start_song(4);
        play_cycles(2, 7 * 9 + 3, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({address, musica_sel, nota_atual, tocando, nota_valida, fim_musica, acertos, erros} !== '0)
            $display("FAIL reset_mid got addr=%0d sel=%0d nota=%b toc=%b val=%b fim=%b ac=%0d er=%0d exp all 0",
                     address, musica_sel, nota_atual, tocando, nota_valida, fim_musica, acertos, erros);
        else passed++;
        start_song(int'($urandom_range(0, 7)));
        play_cycles(2, 113, 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 16; a++) begin
                rom[s][a] = 7'(1 << $urandom_range(0, 6));
                if (s == 7 && $urandom_range(0, 3) == 0) rom[s][a] = 7'd0;
            end
        end
        rom[2][0] = 7'b0000010;

        test_reset();
        test_no_hits();
        test_all_hits();
        test_random_mix();
        test_parar();
        test_start_stop_priority();
        test_restart_from_done();
        test_reset_mid_song();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
